// File: rtl/prbs_error_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs_error_checker
// Purpose  : Self-synchronising PRBS bit-error-rate checker for a differential
//            serial stream; counts bits, bit errors and invalid symbols.
// Revision : 1.0 - initial release
// ============================================================================
module prbs_error_checker #(
    parameter int PRBS_ORDER  = 7,
    parameter int LOCK_COUNT  = 32,
    parameter int WINDOW      = 128,
    parameter int UNLOCK_ERRS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_p,
    input  logic        in_n,
    input  logic        stop,
    input  logic        clear,
    output logic        locked,
    output logic        err_pulse,
    output logic [63:0] errors,
    output logic [63:0] bits,
    output logic [31:0] invalid
);

    localparam int TAP = (PRBS_ORDER == 15) ? 14 : (PRBS_ORDER == 31) ? 28 : 6;
    localparam int SW  = $clog2(PRBS_ORDER + 1);
    localparam int MW  = $clog2(LOCK_COUNT + 1);
    localparam int WW  = $clog2(WINDOW + 1);
    localparam int EW  = $clog2(UNLOCK_ERRS + 1);

    localparam logic [SW-1:0] SEED_LAST  = SW'(PRBS_ORDER - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
    localparam logic [EW-1:0] ERR_LAST   = EW'(UNLOCK_ERRS - 1);

    localparam logic [1:0] ST_SEED   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]            state;
    logic [PRBS_ORDER-1:0] lfsr;
    logic [SW-1:0]         seed_cnt;
    logic [MW-1:0]         match_cnt;
    logic [WW-1:0]         win_cnt;
    logic [EW-1:0]         win_err;

    logic                  rx;
    logic                  sym_invalid;
    logic                  pred;
    logic                  mismatch;
    logic                  in_locked;
    logic [PRBS_ORDER-1:0] lfsr_seed;
    logic [PRBS_ORDER-1:0] lfsr_pred;

    assign rx          = in_p;
    assign sym_invalid = (in_p == in_n);
    assign pred        = lfsr[PRBS_ORDER-1] ^ lfsr[TAP-1];
    assign mismatch    = rx ^ pred;
    assign in_locked   = (state == ST_LOCKED);
    assign lfsr_seed   = {lfsr[PRBS_ORDER-2:0], rx};
    // Once past seeding the reference free-runs so received errors never pollute it.
    assign lfsr_pred   = {lfsr[PRBS_ORDER-2:0], pred};
    assign locked      = in_locked;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_SEED;
            lfsr      <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
        end else begin
            case (state)
                ST_SEED: begin
                    lfsr <= lfsr_seed;
                    if (seed_cnt == SEED_LAST) begin
                        seed_cnt <= '0;
                        if (lfsr_seed != '0) begin
                            state     <= ST_VERIFY;
                            match_cnt <= '0;
                        end
                    end else begin
                        seed_cnt <= seed_cnt + 1'b1;
                    end
                end
                ST_VERIFY: begin
                    lfsr <= lfsr_pred;
                    if (mismatch) begin
                        state     <= ST_SEED;
                        match_cnt <= '0;
                        seed_cnt  <= '0;
                    end else if (match_cnt == MATCH_LAST) begin
                        state     <= ST_LOCKED;
                        match_cnt <= '0;
                        win_cnt   <= '0;
                        win_err   <= '0;
                    end else begin
                        match_cnt <= match_cnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    lfsr <= lfsr_pred;
                    // Unlock wins over a window restart landing on the same bit.
                    if (mismatch && (win_err == ERR_LAST)) begin
                        state    <= ST_SEED;
                        seed_cnt <= '0;
                        win_cnt  <= '0;
                        win_err  <= '0;
                    end else if (win_cnt == WIN_LAST) begin
                        win_cnt <= '0;
                        win_err <= '0;
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                        win_err <= win_err + EW'(mismatch);
                    end
                end
                default: state <= ST_SEED;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_pulse <= 1'b0;
            errors    <= '0;
            bits      <= '0;
            invalid   <= '0;
        end else begin
            err_pulse <= in_locked && mismatch && !stop;
            if (clear) begin
                errors  <= '0;
                bits    <= '0;
                invalid <= '0;
            end else if (!stop) begin
                if (in_locked && (bits != '1))
                    bits <= bits + 1'b1;
                if (in_locked && mismatch && (errors != '1))
                    errors <= errors + 1'b1;
                if (sym_invalid && (invalid != '1))
                    invalid <= invalid + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prbs_error_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs_error_checker
// Purpose  : Scenario bench for prbs_error_checker with a per-cycle scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs_error_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_p  = 1'b0;
    logic        in_n  = 1'b1;
    logic        stop  = 1'b0;
    logic        clear = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [63:0] errors;
    logic [63:0] bits;
    logic [31:0] invalid;

    prbs_error_checker dut (
        .clock     (clock),
        .reset     (reset),
        .in_p      (in_p),
        .in_n      (in_n),
        .stop      (stop),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .errors    (errors),
        .bits      (bits),
        .invalid   (invalid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        locked;
        logic        pulse;
        logic [63:0] errors;
        logic [63:0] bits;
        logic [31:0] invalid;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [6:0]  gen;
    logic        m_locked;
    logic [63:0] m_errors;
    logic [63:0] m_bits;
    logic [31:0] m_invalid;

    always @(negedge clock) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp += 5;
            if (locked !== e.locked) begin
                n_bad++; $display("FAIL sb_locked t=%0t got %b want %b", $time, locked, e.locked);
            end
            if (err_pulse !== e.pulse) begin
                n_bad++; $display("FAIL sb_err_pulse t=%0t got %b want %b", $time, err_pulse, e.pulse);
            end
            if (errors !== e.errors) begin
                n_bad++; $display("FAIL sb_errors t=%0t got %0d want %0d", $time, errors, e.errors);
            end
            if (bits !== e.bits) begin
                n_bad++; $display("FAIL sb_bits t=%0t got %0d want %0d", $time, bits, e.bits);
            end
            if (invalid !== e.invalid) begin
                n_bad++; $display("FAIL sb_invalid t=%0t got %0d want %0d", $time, invalid, e.invalid);
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b1; stop = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset     = 1'b0;
        m_locked  = 1'b0;
        m_errors  = '0;
        m_bits    = '0;
        m_invalid = '0;
    endtask

    // One serial bit: PRBS7 (x^7+x^6+1) unless zero is set; flip corrupts it,
    // inv forces in_p = in_n = 1. The caller states whether lock is expected after it.
    task automatic step(input logic flip, input logic inv, input logic stp,
                        input logic clr, input logic zero, input logic e_locked);
        logic b;
        exp_t e;
        if (zero) begin
            b = 1'b0;
        end else begin
            b   = gen[6] ^ gen[5];
            gen = {gen[5:0], b};
        end
        in_p  = inv ? 1'b1 : (b ^ flip);
        in_n  = inv ? 1'b1 : ~(b ^ flip);
        stop  = stp;
        clear = clr;
        e.pulse = m_locked && flip && !stp;
        if (clr) begin
            m_errors = '0; m_bits = '0; m_invalid = '0;
        end else if (!stp) begin
            if (m_locked) m_bits++;
            if (m_locked && flip) m_errors++;
            if (inv) m_invalid++;
        end
        m_locked  = e_locked;
        e.locked  = e_locked;
        e.errors  = m_errors;
        e.bits    = m_bits;
        e.invalid = m_invalid;
        @(posedge clock);
        #1;
        sb.push_back(e);
    endtask

    task automatic lock_up();
        for (int i = 1; i <= 39; i++) step(0, 0, 0, 0, 0, i == 39);
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clock);
        n_cmp++;
        if ({locked, err_pulse, errors, bits, invalid} !== '0) begin
            n_bad++;
            $display("FAIL reset_state got l=%b p=%b e=%0d b=%0d i=%0d want all 0",
                     locked, err_pulse, errors, bits, invalid);
        end
    endtask

    task automatic test_clean_lock();
        apply_reset();
        gen = 7'h7F;
        for (int i = 1; i <= 200; i++) step(0, 0, 0, 0, 0, i >= 39);
        @(negedge clock);
        n_cmp++;
        if (bits !== 64'd161) begin
            n_bad++; $display("FAIL clean_bits got %0d want 161", bits);
        end
        n_cmp++;
        if (errors !== 64'd0 || invalid !== 32'd0) begin
            n_bad++; $display("FAIL clean_errs got e=%0d i=%0d want 0/0", errors, invalid);
        end
    endtask

    task automatic test_single_error();
        step(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);
        @(negedge clock);
        n_cmp++;
        if (errors !== 64'd1 || locked !== 1'b1) begin
            n_bad++; $display("FAIL single_err got e=%0d l=%b want 1/1", errors, locked);
        end
    endtask

    task automatic test_window_restart();
        apply_reset();
        lock_up();
        // 14 errors, 7 per window, must never unlock.
        for (int j = 1; j <= 240; j++) step((j % 16 == 0) && (j != 128), 0, 0, 0, 0, 1);
        @(negedge clock);
        n_cmp++;
        if (errors !== 64'd14 || locked !== 1'b1) begin
            n_bad++; $display("FAIL window_restart got e=%0d l=%b want 14/1", errors, locked);
        end
    endtask

    task automatic test_unlock_relock();
        apply_reset();
        lock_up();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 1);
            step(1, 0, 0, 0, 0, k != 7);
        end
        for (int i = 1; i <= 39; i++) step(0, 0, 0, 0, 0, i == 39);
        @(negedge clock);
        n_cmp++;
        if (errors !== 64'd8 || locked !== 1'b1) begin
            n_bad++; $display("FAIL unlock_relock got e=%0d l=%b want 8/1", errors, locked);
        end
    endtask

    task automatic test_invalid();
        apply_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        @(negedge clock);
        n_cmp++;
        if (invalid !== 32'd3) begin
            n_bad++; $display("FAIL invalid_count got %0d want 3", invalid);
        end
        apply_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
        @(negedge clock);
        n_cmp++;
        if (invalid !== 32'd0) begin
            n_bad++; $display("FAIL invalid_stopped got %0d want 0", invalid);
        end
    endtask

    task automatic test_stop_clear();
        apply_reset();
        lock_up();
        for (int i = 0; i < 10; i++) step(i == 4, 0, 0, 0, 0, 1);
        for (int i = 0; i < 50; i++) step(i % 10 == 3, 0, 1, 0, 0, 1);
        @(negedge clock);
        n_cmp++;
        if (errors !== 64'd1 || bits !== 64'd10 || locked !== 1'b1) begin
            n_bad++; $display("FAIL stop_freeze got e=%0d b=%0d l=%b want 1/10/1", errors, bits, locked);
        end
        step(0, 0, 0, 1, 0, 1);
        @(negedge clock);
        n_cmp++;
        if (errors !== 64'd0 || bits !== 64'd0 || invalid !== 32'd0 || locked !== 1'b1) begin
            n_bad++; $display("FAIL clear got e=%0d b=%0d i=%0d l=%b want 0/0/0/1", errors, bits, invalid, locked);
        end
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_zero_and_reset();
        apply_reset();
        for (int i = 0; i < 500; i++) step(0, 0, 0, 0, 1, 0);
        @(negedge clock);
        n_cmp++;
        if (bits !== 64'd0 || locked !== 1'b0) begin
            n_bad++; $display("FAIL zero_stream got b=%0d l=%b want 0/0", bits, locked);
        end
        apply_reset();
        lock_up();
        for (int i = 0; i < 5; i++) step(i == 2, 0, 0, 0, 0, 1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        n_cmp++;
        if ({locked, err_pulse, errors, bits, invalid} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_lock got l=%b e=%0d b=%0d i=%0d want all 0", locked, errors, bits, invalid);
        end
        reset = 1'b0;
    endtask

    initial begin
        gen = 7'h7F;
        test_reset();
        test_clean_lock();
        test_single_error();
        test_window_restart();
        test_unlock_relock();
        test_invalid();
        test_stop_clear();
        test_zero_and_reset();
        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
